// File: rtl/bullet_pkg.sv
// Shared constants for the bullet pool: default geometry and direction encoding.
// No logic or latency; imported by the pool and the per-slot module.
// No flow control; values only.
package bullet_pkg;

  localparam int COORD_W_DEF  = 10;
  localparam int SCREEN_H_DEF = 480;
  localparam int SHIP_Y_DEF   = 240;

  // Direction bit stored per slot: 1 moves toward y = 0, 0 moves toward SCREEN_H.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position/direction/active state, per-frame motion, retire/kill, pixel hit.
// Latency: spawn/move/retire/kill take effect at the next clk edge; bw_o is combinational from state.
// No backpressure: spawn_i is only asserted by the pool when this slot is free.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SHIP_Y   = SHIP_Y_DEF,
  parameter int SPEED    = 4,
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               spawn_i,
  input  logic [COORD_W-1:0] spawn_x_i,
  input  logic               dir_i,
  input  logic               kill_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic               active_o,
  output logic               active_d_o,
  output logic               bw_o
);

  // All limits widened by one bit so sums and compares can never wrap.
  localparam logic [COORD_W:0]   SPEED_X    = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0]   SCREEN_H_X = (COORD_W+1)'(SCREEN_H);
  localparam logic [COORD_W:0]   BW_X       = (COORD_W+1)'(BULLET_W);
  localparam logic [COORD_W:0]   BH_X       = (COORD_W+1)'(BULLET_H);
  localparam logic [COORD_W-1:0] SHIP_Y_C   = COORD_W'(SHIP_Y);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               dir_q, dir_d;
  logic               active_q, active_d;
  logic [COORD_W:0]   down_sum;

  assign down_sum = {1'b0, y_q} + SPEED_X;

  // Next state: spawn loads a fresh bullet (no motion that cycle); kill beats motion; edges retire.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    active_d = active_q;
    if (spawn_i) begin
      x_d      = spawn_x_i;
      y_d      = SHIP_Y_C;
      dir_d    = dir_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (kill_i) begin
        active_d = 1'b0;
      end else if (dir_q == DIR_UP) begin
        if ({1'b0, y_q} < SPEED_X) active_d = 1'b0;
        else                       y_d = y_q - SPEED_X[COORD_W-1:0];
      end else begin
        if (down_sum >= SCREEN_H_X) active_d = 1'b0;
        else                        y_d = down_sum[COORD_W-1:0];
      end
    end
  end

  // Slot state registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= DIR_DOWN;
      active_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      active_q <= active_d;
    end
  end

  assign active_o   = active_q;
  assign active_d_o = active_d;

  // Pixel hit: the scanner position lies inside the BULLET_W x BULLET_H box of an active bullet.
  assign bw_o = active_q
             && ({1'b0, x_i} >= {1'b0, x_q}) && ({1'b0, x_i} < ({1'b0, x_q} + BW_X))
             && ({1'b0, y_i} >= {1'b0, y_q}) && ({1'b0, y_i} < ({1'b0, y_q} + BH_X));

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: edge-detected fire requests, lowest-free-slot allocation, refire cooldown, slot array.
// Latency: accepted shot shows on inUse/fire_ack one cycle after the request edge.
// No backpressure: requests arriving while full or cooling down are dropped, never queued.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int SHIP_Y      = SHIP_Y_DEF,
  parameter int SPEED       = 4,
  parameter int COOLDOWN    = 8,
  parameter int BULLET_W    = 2,
  parameter int BULLET_H    = 4,
  localparam int CNT_W      = $clog2(NUM_BULLETS + 1)
) (
  input  logic                   clk_60hz,
  input  logic                   reset,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  input  logic [COORD_W-1:0]     shipx,
  input  logic                   shootUp,
  input  logic                   shootDown,
  input  logic [NUM_BULLETS-1:0] kill,
  output logic [NUM_BULLETS-1:0] BW,
  output logic [NUM_BULLETS-1:0] inUse,
  output logic                   fire_ack,
  output logic [CNT_W-1:0]       active_count
);

  // A zero cooldown still needs a one-bit counter that simply stays at 0.
  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic                   shoot, shoot_prev_q, req, accept, dir_req;
  logic [CD_W-1:0]        cd_q, cd_d;
  logic                   fire_ack_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_BULLETS-1:0] free, lowest_free, spawn, act_d;

  assign shoot   = shootUp | shootDown;
  assign req     = shoot & ~shoot_prev_q;
  assign dir_req = shootUp ? DIR_UP : DIR_DOWN;

  // Free slots come from registered state, so a slot freed this edge is usable only next edge.
  assign free        = ~inUse;
  assign lowest_free = free & (-free);
  assign accept      = req && (cd_q == '0) && (free != '0);
  assign spawn       = accept ? lowest_free : '0;

  // Cooldown reloads on every accepted shot and otherwise counts down to 0.
  always_comb begin
    cd_d = cd_q;
    if (accept)          cd_d = CD_W'(COOLDOWN);
    else if (cd_q != '0) cd_d = cd_q - CD_W'(1);
  end

  // Popcount of next-state active bits so the count lines up with inUse.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_BULLETS; i++) cnt_d = cnt_d + CNT_W'(act_d[i]);
  end

  // Pool-level registers: request edge detect, cooldown, ack pulse and active count.
  always_ff @(posedge clk_60hz or posedge reset) begin
    if (reset) begin
      shoot_prev_q <= 1'b0;
      cd_q         <= '0;
      fire_ack_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      shoot_prev_q <= shoot;
      cd_q         <= cd_d;
      fire_ack_q   <= accept;
      cnt_q        <= cnt_d;
    end
  end

  assign fire_ack     = fire_ack_q;
  assign active_count = cnt_q;

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .COORD_W  (COORD_W),
      .SCREEN_H (SCREEN_H),
      .SHIP_Y   (SHIP_Y),
      .SPEED    (SPEED),
      .BULLET_W (BULLET_W),
      .BULLET_H (BULLET_H)
    ) u_slot (
      .clk_i      (clk_60hz),
      .rst_i      (reset),
      .spawn_i    (spawn[i]),
      .spawn_x_i  (shipx),
      .dir_i      (dir_req),
      .kill_i     (kill[i]),
      .x_i        (x),
      .y_i        (y),
      .active_o   (inUse[i]),
      .active_d_o (act_d[i]),
      .bw_o       (BW[i])
    );
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench: DUT A uses COOLDOWN=8, DUT B uses COOLDOWN=0; both share the input pins.
// Directed vector table on DUT B plus hand sequences for cooldown, motion, retirement and async reset.
// Outputs are sampled 1 time unit after the rising edge.
module tb_bullet_pool;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y, shipx;
  logic       up, down;
  logic [3:0] kill;

  logic [3:0] bw_a, inuse_a, bw_b, inuse_b;
  logic       ack_a, ack_b;
  logic [2:0] cnt_a, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bullet_pool #(.NUM_BULLETS(4), .COOLDOWN(8)) dut_a (
    .clk_60hz(clk), .reset(reset), .x(x), .y(y), .shipx(shipx),
    .shootUp(up), .shootDown(down), .kill(kill),
    .BW(bw_a), .inUse(inuse_a), .fire_ack(ack_a), .active_count(cnt_a)
  );

  bullet_pool #(.NUM_BULLETS(4), .COOLDOWN(0)) dut_b (
    .clk_60hz(clk), .reset(reset), .x(x), .y(y), .shipx(shipx),
    .shootUp(up), .shootDown(down), .kill(kill),
    .BW(bw_b), .inUse(inuse_b), .fire_ack(ack_b), .active_count(cnt_b)
  );

  typedef struct {
    logic       up;
    logic       down;
    logic [3:0] kill;
    logic [9:0] shipx;
    logic [9:0] px;
    logic [9:0] py;
    logic [3:0] e_inuse;
    logic       e_ack;
    logic [3:0] e_bw;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int u, input int d, input int k, input int sx, input int px, input int py);
    up    = (u != 0);
    down  = (d != 0);
    kill  = 4'(k);
    shipx = 10'(sx);
    x     = 10'(px);
    y     = 10'(py);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    up    = 1'b0;
    down  = 1'b0;
    kill  = '0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    int acks;
    int rk;

    //            up    dn    kill     shipx  x      y       inUse    ack   bw       cnt
    vt[0]  = '{1'b1, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd240, 4'b0001, 1'b1, 4'b0001, 3'd1};
    vt[1]  = '{1'b0, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd240, 4'b0001, 1'b0, 4'b0000, 3'd1};
    vt[2]  = '{1'b1, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd240, 4'b0011, 1'b1, 4'b0010, 3'd2};
    vt[3]  = '{1'b0, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd236, 4'b0011, 1'b0, 4'b0010, 3'd2};
    vt[4]  = '{1'b1, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd240, 4'b0111, 1'b1, 4'b0100, 3'd3};
    vt[5]  = '{1'b0, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd236, 4'b0111, 1'b0, 4'b0100, 3'd3};
    vt[6]  = '{1'b1, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd240, 4'b1111, 1'b1, 4'b1000, 3'd4};
    vt[7]  = '{1'b0, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd212, 4'b1111, 1'b0, 4'b0001, 3'd4};
    vt[8]  = '{1'b1, 1'b0, 4'b0000, 10'd50, 10'd50, 10'd224, 4'b1111, 1'b0, 4'b0100, 3'd4};
    vt[9]  = '{1'b0, 1'b0, 4'b0100, 10'd50, 10'd50, 10'd212, 4'b1011, 1'b0, 4'b0010, 3'd3};
    vt[10] = '{1'b1, 1'b0, 4'b0000, 10'd80, 10'd80, 10'd240, 4'b1111, 1'b1, 4'b0100, 3'd4};
    vt[11] = '{1'b0, 1'b0, 4'b1000, 10'd80, 10'd80, 10'd236, 4'b0111, 1'b0, 4'b0100, 3'd3};
    vt[12] = '{1'b0, 1'b0, 4'b1000, 10'd80, 10'd80, 10'd232, 4'b0111, 1'b0, 4'b0100, 3'd3};
    vt[13] = '{1'b1, 1'b0, 4'b0001, 10'd80, 10'd80, 10'd240, 4'b1110, 1'b1, 4'b1000, 3'd3};
    vt[14] = '{1'b0, 1'b0, 4'b0000, 10'd80, 10'd80, 10'd224, 4'b1110, 1'b0, 4'b0100, 3'd3};

    // Reset state
    reset = 1'b1; up = 1'b0; down = 1'b0; kill = '0;
    shipx = '0; x = '0; y = '0;
    #2;
    chk("rst inUse", 32'(inuse_a), 'b0000);
    chk("rst fire_ack", 32'(ack_a), 0);
    chk("rst count", 32'(cnt_a), 0);
    chk("rst BW", 32'(bw_a), 0);
    chk("rst inUse B", 32'(inuse_b), 0);
    #10;
    reset = 1'b0;

    // Fill/kill/reuse table on the no-cooldown pool
    for (int i = 0; i < 15; i++) begin
      step(int'(vt[i].up), int'(vt[i].down), int'(vt[i].kill),
           int'(vt[i].shipx), int'(vt[i].px), int'(vt[i].py));
      chk($sformatf("vec%0d inUse", i), 32'(inuse_b), 32'(vt[i].e_inuse));
      chk($sformatf("vec%0d fire_ack", i), 32'(ack_b), 32'(vt[i].e_ack));
      chk($sformatf("vec%0d BW", i), 32'(bw_b), 32'(vt[i].e_bw));
      chk($sformatf("vec%0d count", i), 32'(cnt_b), 32'(vt[i].e_cnt));
    end

    // Spawn at shipx=100, pixel box edges, held level fires once, upward retirement
    do_reset();
    step(1, 0, 0, 100, 100, 240);
    chk("spawn inUse", 32'(inuse_a), 'b0001);
    chk("spawn ack", 32'(ack_a), 1);
    chk("spawn BW x100", 32'(bw_a), 'b0001);
    x = 10'd101; #1;
    chk("spawn BW x101", 32'(bw_a), 'b0001);
    x = 10'd102; #1;
    chk("spawn BW x102", 32'(bw_a), 'b0000);
    acks = 0;
    for (int k = 1; k < 20; k++) begin
      step(1, 0, 0, 100, 100, 200);
      acks += int'(ack_a);
      if (k == 9)  chk("up y204 BW at 200", 32'(bw_a[0]), 0);
      if (k == 10) chk("up y200 BW at 200", 32'(bw_a[0]), 1);
    end
    chk("held level extra acks", 32'(acks), 0);
    rk = -1;
    for (int k = 20; k <= 80; k++) begin
      step(0, 0, 0, 100, 100, 0);
      if (k == 60) chk("up y0 BW at 0", 32'(bw_a[0]), 1);
      if (rk < 0 && !inuse_a[0]) rk = k;
    end
    chk("up retire cycle", 32'(rk), 61);
    chk("up retire count", 32'(cnt_a), 0);

    // Cooldown: reject at +3, accept at +9
    do_reset();
    step(1, 0, 0, 20, 0, 0);
    chk("cd first ack", 32'(ack_a), 1);
    step(0, 0, 0, 20, 0, 0);
    step(0, 0, 0, 20, 0, 0);
    step(1, 0, 0, 20, 0, 0);
    chk("cd +3 ack", 32'(ack_a), 0);
    chk("cd +3 inUse", 32'(inuse_a), 'b0001);
    for (int i = 4; i <= 8; i++) step(0, 0, 0, 20, 0, 0);
    step(1, 0, 0, 20, 0, 0);
    chk("cd +9 ack", 32'(ack_a), 1);
    chk("cd +9 inUse", 32'(inuse_a), 'b0011);

    // Both inputs rising together fires upward
    do_reset();
    step(1, 1, 0, 300, 300, 236);
    chk("both ack", 32'(ack_a), 1);
    step(0, 0, 0, 300, 300, 236);
    chk("both moved up", 32'(bw_a), 'b0001);

    // Downward shot at shipx=0, retire at the bottom edge without wrapping
    do_reset();
    step(0, 1, 0, 0, 0, 244);
    chk("down spawn not moved", 32'(bw_a), 'b0000);
    step(0, 0, 0, 0, 0, 244);
    chk("down y244", 32'(bw_a), 'b0001);
    x = 10'd2; #1;
    chk("down x2 miss", 32'(bw_a), 'b0000);
    rk = -1;
    for (int k = 2; k <= 70; k++) begin
      step(0, 0, 0, 0, 0, 479);
      if (k == 59) chk("down y476 BW at 479", 32'(bw_a[0]), 1);
      if (rk < 0 && !inuse_a[0]) rk = k;
    end
    chk("down retire cycle", 32'(rk), 60);

    // Async reset with three bullets active, then first edge after release fires again
    do_reset();
    step(1, 0, 0, 60, 60, 240);
    step(0, 0, 0, 60, 60, 240);
    step(1, 0, 0, 60, 60, 240);
    step(0, 0, 0, 60, 60, 240);
    step(1, 0, 0, 60, 60, 240);
    chk("pre-reset inUse", 32'(inuse_b), 'b0111);
    chk("pre-reset BW", 32'(bw_b), 'b0100);
    #2;
    reset = 1'b1;
    #1;
    chk("async inUse", 32'(inuse_b), 0);
    chk("async BW", 32'(bw_b), 0);
    chk("async count", 32'(cnt_b), 0);
    chk("async ack", 32'(ack_b), 0);
    #1;
    reset = 1'b0;
    step(1, 0, 0, 60, 60, 240);
    chk("post-reset ack", 32'(ack_b), 1);
    chk("post-reset inUse", 32'(inuse_b), 'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
